// File: rtl/random_word_collector_pkg.sv
// Shared definitions for the random-byte consumer and any future producer-side wrapper.
package random_word_collector_pkg;

    // Consumer handshake FSM: waiting for a byte, or holding the acknowledge high.
    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } coll_state_t;

    // Levels of the acknowledge line in the four-phase byte handshake.
    localparam logic RCV_LOW  = 1'b0;
    localparam logic RCV_HIGH = 1'b1;

    localparam int BYTE_W = 8;

endpackage

// File: rtl/random_word_collector_health.sv
// Repetition-count health test: flags a run of REPEAT_LIMIT identical bytes.
module repetition_health_test
    import random_word_collector_pkg::*;
#(
    parameter int REPEAT_LIMIT = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              strobe,
    input  logic [BYTE_W-1:0] data_byte,
    output logic              fault
);

    localparam logic [7:0] LIMIT = 8'(REPEAT_LIMIT);

    logic [BYTE_W-1:0] last_byte;
    logic [7:0]        rep_cnt;
    logic [7:0]        rep_nxt;
    logic              first;

    // Length of the current run once this byte is counted; saturates at the limit.
    always_comb begin
        rep_nxt = 8'd1;
        if (data_byte == last_byte && !first)
            rep_nxt = (rep_cnt >= LIMIT) ? LIMIT : rep_cnt + 8'd1;
    end

    // Track the last byte and run length; the fault stays set until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_byte <= '0;
            rep_cnt   <= '0;
            first     <= 1'b1;
            fault     <= 1'b0;
        end else if (strobe) begin
            last_byte <= data_byte;
            rep_cnt   <= rep_nxt;
            first     <= 1'b0;
            if (rep_nxt == LIMIT)
                fault <= 1'b1;
        end
    end

endmodule

// File: rtl/random_word_collector.sv
// Collects BYTES handshaked random bytes into one word, MSB-first, with a health check.
module random_word_collector
    import random_word_collector_pkg::*;
#(
    parameter int BYTES        = 4,
    parameter int REPEAT_LIMIT = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [BYTE_W-1:0]     in_data,
    input  logic                  in_valid,
    output logic                  in_received,
    output logic [8*BYTES-1:0]    word,
    output logic                  word_valid,
    input  logic                  word_ack,
    output logic                  health_fault
);

    localparam int              WORD_W   = 8 * BYTES;
    localparam int              CNT_W    = $clog2(BYTES + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BYTES - 1);

    coll_state_t       state, state_nxt;
    logic              capture;
    logic              wv_q;
    logic [CNT_W-1:0]  byte_cnt;
    logic [WORD_W-1:0] word_shift;

    // A faulted source never presents a word, and the mask keeps that true even
    // when the fault lands on the same edge that completes a word.
    assign word_valid  = wv_q & ~health_fault;
    assign in_received = (state == ACK) ? RCV_HIGH : RCV_LOW;

    // Handshake next state; a pending word blocks capture unless the source has faulted,
    // so bytes keep flowing and the producer cannot deadlock.
    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid && (!wv_q || health_fault)) begin
                    capture   = 1'b1;
                    state_nxt = ACK;
                end
            end
            ACK: begin
                if (!in_valid)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake state register.
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Word shifted one byte left with the new byte appended in the LSBs.
    always_comb begin
        word_shift      = word << 8;
        word_shift[7:0] = in_data;
    end

    // Word assembly, byte counting and valid/ack; ack only matters while a word is shown.
    always_ff @(posedge clk) begin
        if (rst) begin
            word     <= '0;
            byte_cnt <= '0;
            wv_q     <= 1'b0;
        end else if (capture) begin
            word <= word_shift;
            if (byte_cnt == LAST_IDX) begin
                byte_cnt <= '0;
                wv_q     <= 1'b1;
            end else begin
                byte_cnt <= byte_cnt + 1'b1;
            end
        end else if (word_valid && word_ack) begin
            wv_q <= 1'b0;
        end
    end

    repetition_health_test #(
        .REPEAT_LIMIT(REPEAT_LIMIT)
    ) u_health (
        .clk      (clk),
        .rst      (rst),
        .strobe   (capture),
        .data_byte(in_data),
        .fault    (health_fault)
    );

endmodule

// File: tb/tb_random_word_collector.sv
// Directed bench: stimulus pushes expected words, a negedge monitor checks each presented word.
module tb_random_word_collector;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_received;
    logic [31:0] word;
    logic        word_valid;
    logic        word_ack;
    logic        health_fault;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_q[$];
    logic        prev_wv  = 1'b0;

    always #5 clk = ~clk;

    random_word_collector #(.BYTES(4), .REPEAT_LIMIT(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_received (in_received),
        .word        (word),
        .word_valid  (word_valid),
        .word_ack    (word_ack),
        .health_fault(health_fault)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitor: every rising word_valid must match the oldest expected word.
    always @(negedge clk) begin
        if (word_valid === 1'b1 && prev_wv !== 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_word actual=%h expected=none", word);
            end else begin
                chk("word", word, exp_q.pop_front());
            end
        end
        prev_wv = word_valid;
    end

    // Producer side of the four-phase handshake; hold = extra cycles in_valid stays up.
    task automatic send_byte(input logic [7:0] b, input int hold, output bit ok);
        ok = 1'b0;
        @(posedge clk); #1;
        in_data  = b;
        in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_received === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL handshake_ack actual=timeout expected=in_received byte=%h", b);
            in_valid = 1'b0;
            return;
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_received", in_received, 1);
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("release", in_received, 0);
    endtask

    task automatic ack_word(input logic [31:0] exp);
        bit seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (word_valid === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL word_valid_wait actual=timeout expected=%h", exp);
            return;
        end
        @(posedge clk); #1 word_ack = 1'b1;
        @(posedge clk); #1 word_ack = 1'b0;
        @(negedge clk);
        chk("ack_clears_valid", word_valid, 0);
        chk("word_after_ack", word, exp);
    endtask

    task automatic send_word(input logic [31:0] w);
        bit ok;
        exp_q.push_back(w);
        for (int i = 3; i >= 0; i--)
            send_byte(w[i*8 +: 8], 0, ok);
        ack_word(w);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        bit ok;
        int n;
        logic stall_ok;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; word_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_word", word, 0);
        chk("reset_valid", word_valid, 0);
        chk("reset_received", in_received, 0);
        chk("reset_fault", health_fault, 0);

        // 1: basic collection, word left pending for the backpressure test
        exp_q.push_back(32'h087b2de2);
        send_byte(8'h08, 0, ok);
        send_byte(8'h7b, 0, ok);
        send_byte(8'h2d, 0, ok);
        send_byte(8'he2, 0, ok);
        chk("t1_valid", word_valid, 1);

        // 2: backpressure, then ack together with a waiting byte
        @(posedge clk); #1;
        in_data = 8'h11; in_valid = 1'b1;
        stall_ok = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (in_received !== 1'b0 || word !== 32'h087b2de2 || word_valid !== 1'b1)
                stall_ok = 1'b0;
        end
        chk("backpressure_stall", stall_ok, 1);
        @(posedge clk); #1 word_ack = 1'b1;
        @(posedge clk); #1 word_ack = 1'b0;
        @(negedge clk);
        chk("t2_ack_valid", word_valid, 0);
        chk("t2_no_early_capture", in_received, 0);
        chk("t2_word_held", word, 32'h087b2de2);
        @(negedge clk);
        chk("t2_capture", in_received, 1);
        chk("t2_word_shift", word, 32'h7b2de211);
        in_valid = 1'b0;
        @(negedge clk);
        chk("t2_release", in_received, 0);
        exp_q.push_back(32'h11223344);
        send_byte(8'h22, 0, ok);
        send_byte(8'h33, 0, ok);
        send_byte(8'h44, 0, ok);
        ack_word(32'h11223344);

        // 3: health test
        send_word(32'h00000000);
        send_word(32'h00000001);
        chk("t3_no_fault_7", health_fault, 0);
        send_word(32'h55555555);
        send_byte(8'h55, 0, ok);
        send_byte(8'h55, 0, ok);
        send_byte(8'h55, 0, ok);
        chk("t3_no_fault_before_8th", health_fault, 0);
        send_byte(8'h55, 0, ok);
        chk("t3_fault", health_fault, 1);
        chk("t3_fault_valid", word_valid, 0);
        n = 0;
        for (int i = 0; i < 8; i++) begin
            send_byte(8'(i * 37 + 3), 0, ok);
            if (ok) n++;
        end
        chk("t3_fault_handshakes", n, 8);
        chk("t3_valid_stays_low", word_valid, 0);
        chk("t3_fault_sticky", health_fault, 1);

        // 6: reset clears the fault, collection resumes
        pulse_reset();
        chk("t6_fault_cleared", health_fault, 0);
        chk("t6_word", word, 0);
        send_word(32'hdeadbeef);

        // 4: reset mid-word with in_valid held high
        send_byte(8'haa, 0, ok);
        send_byte(8'hbb, 0, ok);
        exp_q.push_back(32'h01020304);
        @(posedge clk); #1;
        rst = 1'b1; in_data = 8'h01; in_valid = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("t4_rst_word", word, 0);
        chk("t4_rst_valid", word_valid, 0);
        chk("t4_rst_received", in_received, 0);
        chk("t4_rst_fault", health_fault, 0);
        @(negedge clk);
        chk("t4_fresh_capture", in_received, 1);
        in_valid = 1'b0;
        @(negedge clk);
        chk("t4_release", in_received, 0);
        send_byte(8'h02, 0, ok);
        send_byte(8'h03, 0, ok);
        send_byte(8'h04, 0, ok);
        ack_word(32'h01020304);

        // 5: slow producer, single capture per byte
        exp_q.push_back(32'h10203040);
        send_byte(8'h10, 10, ok);
        chk("t5_single_capture", word[7:0], 8'h10);
        send_byte(8'h20, 0, ok);
        send_byte(8'h30, 0, ok);
        send_byte(8'h40, 0, ok);
        ack_word(32'h10203040);

        repeat (3) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
